// File: rtl/median_pkg.sv
// Shared constants for the 3x3 median/min/max window sorter.
package median_pkg;

    localparam logic [1:0] MODE_MED = 2'd0;
    localparam logic [1:0] MODE_MIN = 2'd1;
    localparam logic [1:0] MODE_MAX = 2'd2;

    localparam int PIPE_LATENCY = 3;

endpackage

// File: rtl/sort3_cell.sv
// Combinational 3-input unsigned sorter built from three compare-swaps.
module sort3_cell #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] c,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] mid,
    output logic [DATA_WIDTH-1:0] lo
);

    logic [DATA_WIDTH-1:0] ab_hi;
    logic [DATA_WIDTH-1:0] ab_lo;
    logic [DATA_WIDTH-1:0] bc_hi;

    // Swap 1 orders a/b, swap 2 sinks the minimum, swap 3 orders the top pair.
    assign ab_hi = (a >= b) ? a : b;
    assign ab_lo = (a >= b) ? b : a;
    assign bc_hi = (ab_lo >= c) ? ab_lo : c;
    assign lo    = (ab_lo >= c) ? c : ab_lo;
    assign hi    = (ab_hi >= bc_hi) ? ab_hi : bc_hi;
    assign mid   = (ab_hi >= bc_hi) ? bc_hi : ab_hi;

endmodule

// File: rtl/median3x3_pipe.sv
// Three-stage 3x3 window sorter: column sort, row-of-ranks reduction, final select.
module median3x3_pipe
    import median_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_stall,
    input  logic                    i_valid,
    input  logic [1:0]              i_mode,
    input  logic [9*DATA_WIDTH-1:0] i_window,
    output logic                    o_valid,
    output logic [DATA_WIDTH-1:0]   o_data
);

    localparam int W = DATA_WIDTH;

    logic [W-1:0] col_hi  [3];
    logic [W-1:0] col_mid [3];
    logic [W-1:0] col_lo  [3];

    logic [W-1:0] hi_p0  [3];
    logic [W-1:0] mid_p0 [3];
    logic [W-1:0] lo_p0  [3];
    logic [1:0]   mode_p0;
    logic         vld_p0;

    logic [W-1:0] a_p1, b_p1, c_p1, mn_p1, mx_p1;
    logic [1:0]   mode_p1;
    logic         vld_p1;

    logic [W-1:0] lo_max, lo_min, mid_med, hi_min, hi_max, med_abc;
    logic [W-1:0] unused_lo_mid, unused_mid_hi, unused_mid_lo, unused_hi_mid;
    logic [W-1:0] unused_abc_hi, unused_abc_lo;
    logic [W-1:0] result;

    // ---- Stage 1: sort each column (c0 = p0,p3,p6 ...) ----
    for (genvar col = 0; col < 3; col++) begin : g_col
        sort3_cell #(.DATA_WIDTH(W)) u_col (
            .a   (i_window[col*W +: W]),
            .b   (i_window[(col+3)*W +: W]),
            .c   (i_window[(col+6)*W +: W]),
            .hi  (col_hi[col]),
            .mid (col_mid[col]),
            .lo  (col_lo[col])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                hi_p0[k]  <= '0;
                mid_p0[k] <= '0;
                lo_p0[k]  <= '0;
            end
            mode_p0 <= '0;
            vld_p0  <= 1'b0;
        end else if (!i_stall) begin
            hi_p0   <= col_hi;
            mid_p0  <= col_mid;
            lo_p0   <= col_lo;
            mode_p0 <= i_mode;
            vld_p0  <= i_valid;
        end
    end

    // ---- Stage 2: max of lows, median of mids, min of highs, plus global min/max ----
    sort3_cell #(.DATA_WIDTH(W)) u_lows (
        .a(lo_p0[0]), .b(lo_p0[1]), .c(lo_p0[2]),
        .hi(lo_max), .mid(unused_lo_mid), .lo(lo_min)
    );
    sort3_cell #(.DATA_WIDTH(W)) u_mids (
        .a(mid_p0[0]), .b(mid_p0[1]), .c(mid_p0[2]),
        .hi(unused_mid_hi), .mid(mid_med), .lo(unused_mid_lo)
    );
    sort3_cell #(.DATA_WIDTH(W)) u_highs (
        .a(hi_p0[0]), .b(hi_p0[1]), .c(hi_p0[2]),
        .hi(hi_max), .mid(unused_hi_mid), .lo(hi_min)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_p1    <= '0;
            b_p1    <= '0;
            c_p1    <= '0;
            mn_p1   <= '0;
            mx_p1   <= '0;
            mode_p1 <= '0;
            vld_p1  <= 1'b0;
        end else if (!i_stall) begin
            a_p1    <= lo_max;
            b_p1    <= mid_med;
            c_p1    <= hi_min;
            mn_p1   <= lo_min;
            mx_p1   <= hi_max;
            mode_p1 <= mode_p0;
            vld_p1  <= vld_p0;
        end
    end

    // ---- Stage 3: median of A/B/C or the extreme chosen by the sample's mode ----
    sort3_cell #(.DATA_WIDTH(W)) u_abc (
        .a(a_p1), .b(b_p1), .c(c_p1),
        .hi(unused_abc_hi), .mid(med_abc), .lo(unused_abc_lo)
    );

    always_comb begin
        result = med_abc;
        case (mode_p1)
            MODE_MIN: result = mn_p1;
            MODE_MAX: result = mx_p1;
            default:  result = med_abc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_data  <= '0;
            o_valid <= 1'b0;
        end else if (!i_stall) begin
            o_data  <= result;
            o_valid <= vld_p1;
        end
    end

endmodule

// File: tb/tb_median3x3_pipe.sv
// Bench for median3x3_pipe: directed scenarios plus a scoreboard over 8- and 12-bit instances.
module tb_median3x3_pipe;
    import median_pkg::*;

    localparam int W8  = 8;
    localparam int W12 = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              stall;
    logic              valid;
    logic [1:0]        mode;
    logic [9*W8-1:0]   win8;
    logic [9*W12-1:0]  win12;
    logic              ov8, ov12;
    logic [W8-1:0]     od8;
    logic [W12-1:0]    od12;

    int p8[9];
    int p12[9];
    int q8[$];
    int q12[$];
    int tests = 0;
    int fails = 0;

    int wa[9] = '{10, 20, 15, 50, 30, 40, 5, 25, 15};
    int wb[9] = '{7, 7, 7, 1, 2, 3, 9, 9, 9};
    int wc[9] = '{0, 0, 0, 0, 0, 9, 9, 9, 9};
    int wd[9] = '{255, 255, 255, 255, 255, 0, 0, 0, 0};
    int wf[9] = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
    int wm[9] = '{0, 0, 0, 0, 255, 255, 255, 255, 255};

    always #5 clk = ~clk;

    median3x3_pipe #(.DATA_WIDTH(W8)) dut8 (
        .clk(clk), .rst_n(rst_n), .i_stall(stall), .i_valid(valid),
        .i_mode(mode), .i_window(win8), .o_valid(ov8), .o_data(od8)
    );

    median3x3_pipe #(.DATA_WIDTH(W12)) dut12 (
        .clk(clk), .rst_n(rst_n), .i_stall(stall), .i_valid(valid),
        .i_mode(mode), .i_window(win12), .o_valid(ov12), .o_data(od12)
    );

    function automatic int model(input int p[9], input logic [1:0] m);
        int s[9];
        int t;
        s = p;
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (s[j] > s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
        case (m)
            MODE_MIN: return s[0];
            MODE_MAX: return s[8];
            default:  return s[4];
        endcase
    endfunction

    task automatic drive(input logic v, input logic s, input logic [1:0] m,
                         input int a[9], input int b[9]);
        valid = v;
        stall = s;
        mode  = m;
        for (int k = 0; k < 9; k++) begin
            p8[k]  = a[k];
            p12[k] = b[k];
            win8[k*W8 +: W8]    = a[k][W8-1:0];
            win12[k*W12 +: W12] = b[k][W12-1:0];
        end
    endtask

    // Pushes accepted samples at each edge, pops on every new output, checks holds on stalled edges.
    task automatic scoreboard();
        logic st_q, rs_q, pv8, pv12, have_prev;
        logic [W8-1:0]  pd8;
        logic [W12-1:0] pd12;
        int e;
        have_prev = 1'b0;
        pv8 = 1'b0; pv12 = 1'b0; pd8 = '0; pd12 = '0;
        forever begin
            @(posedge clk);
            st_q = stall;
            rs_q = rst_n;
            if (!rst_n) begin
                q8.delete();
                q12.delete();
            end else if (!stall && valid) begin
                q8.push_back(model(p8, mode));
                q12.push_back(model(p12, mode));
            end
            @(negedge clk);
            if (rs_q && st_q && have_prev) begin
                tests++;
                if (ov8 !== pv8 || od8 !== pd8 || ov12 !== pv12 || od12 !== pd12) begin
                    fails++;
                    $display("FAIL stall_hold: got v8=%b d8=%0d v12=%b d12=%0d, need v8=%b d8=%0d v12=%b d12=%0d",
                             ov8, od8, ov12, od12, pv8, pd8, pv12, pd12);
                end
            end
            if (rs_q && !st_q && ov8 === 1'b1) begin
                tests++;
                if (q8.size() == 0) begin
                    fails++;
                    $display("FAIL sb8_unexpected: got d8=%0d, need no output", od8);
                end else begin
                    e = q8.pop_front();
                    if (od8 !== e[W8-1:0]) begin
                        fails++;
                        $display("FAIL sb8_data: got %0d, need %0d", od8, e);
                    end
                end
            end
            if (rs_q && !st_q && ov12 === 1'b1) begin
                tests++;
                if (q12.size() == 0) begin
                    fails++;
                    $display("FAIL sb12_unexpected: got d12=%0d, need no output", od12);
                end else begin
                    e = q12.pop_front();
                    if (od12 !== e[W12-1:0]) begin
                        fails++;
                        $display("FAIL sb12_data: got %0d, need %0d", od12, e);
                    end
                end
            end
            pv8 = ov8; pd8 = od8; pv12 = ov12; pd12 = od12;
            have_prev = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b0, MODE_MED, wa, wa);
        repeat (3) @(negedge clk);
        tests++;
        if (ov8 !== 1'b0 || od8 !== '0 || ov12 !== 1'b0 || od12 !== '0) begin
            fails++;
            $display("FAIL reset_state: got v8=%b d8=%0d v12=%b d12=%0d, need all 0", ov8, od8, ov12, od12);
        end
        rst_n = 1'b1;
        drive(1'b0, 1'b0, MODE_MED, wa, wa);
        repeat (3) @(negedge clk);
        tests++;
        if (ov8 !== 1'b0 || ov12 !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: got v8=%b v12=%b, need 0", ov8, ov12);
        end
    endtask

    task automatic test_median();
        logic ev[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (n > 0) begin
                tests++;
                if (ov8 !== ev[n] || ov12 !== ev[n] || (ev[n] && (od8 !== 8'd20 || od12 !== 12'd20))) begin
                    fails++;
                    $display("FAIL median_latency n=%0d: got v=%b d=%0d v12=%b d12=%0d, need v=%b d=20",
                             n, ov8, od8, ov12, od12, ev[n]);
                end
            end
            drive(n == 0, 1'b0, MODE_MED, wa, wa);
        end
    endtask

    task automatic test_modes();
        logic [1:0] ms[4] = '{MODE_MIN, MODE_MAX, MODE_MED, 2'd3};
        logic ev[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int   ed[8] = '{0, 0, 0, 5, 50, 20, 20, 0};
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (n > 0) begin
                tests++;
                if (ov8 !== ev[n] || (ev[n] && od8 !== ed[n][W8-1:0])) begin
                    fails++;
                    $display("FAIL modes n=%0d: got v=%b d=%0d, need v=%b d=%0d", n, ov8, od8, ev[n], ed[n]);
                end
            end
            if (n < 4) drive(1'b1, 1'b0, ms[n], wa, wa);
            else       drive(1'b0, 1'b0, MODE_MED, wa, wa);
        end
    endtask

    task automatic test_stall();
        logic ev[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int   ed[10] = '{0, 0, 0, 0, 0, 20, 7, 0, 255, 0};
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (n > 0) begin
                tests++;
                if (ov8 !== ev[n] || (ev[n] && od8 !== ed[n][W8-1:0])) begin
                    fails++;
                    $display("FAIL stall n=%0d: got v=%b d=%0d, need v=%b d=%0d", n, ov8, od8, ev[n], ed[n]);
                end
            end
            case (n)
                0:       drive(1'b1, 1'b0, MODE_MED, wa, wa);
                1:       drive(1'b1, 1'b0, MODE_MED, wb, wb);
                2, 3:    drive(1'b1, 1'b1, MODE_MED, wc, wc);
                4:       drive(1'b1, 1'b0, MODE_MED, wc, wc);
                5:       drive(1'b1, 1'b0, MODE_MED, wd, wd);
                default: drive(1'b0, 1'b0, MODE_MED, wd, wd);
            endcase
        end
    endtask

    task automatic test_extremes();
        logic ev[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int   ed[10] = '{0, 0, 0, 255, 255, 255, 255, 0, 255, 0};
        logic [1:0] ms[3] = '{MODE_MED, MODE_MIN, MODE_MAX};
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (n > 0) begin
                tests++;
                if (ov8 !== ev[n] || (ev[n] && od8 !== ed[n][W8-1:0])) begin
                    fails++;
                    $display("FAIL extremes n=%0d: got v=%b d=%0d, need v=%b d=%0d", n, ov8, od8, ev[n], ed[n]);
                end
            end
            if (n < 3)      drive(1'b1, 1'b0, ms[n], wf, wf);
            else if (n < 6) drive(1'b1, 1'b0, ms[n-3], wm, wm);
            else            drive(1'b0, 1'b0, MODE_MED, wm, wm);
        end
    endtask

    task automatic test_reset_mid();
        for (int n = 0; n < 9; n++) begin
            @(negedge clk);
            if (n == 3) begin
                tests++;
                if (ov8 !== 1'b1 || od8 !== 8'd20) begin
                    fails++;
                    $display("FAIL rst_mid_pre: got v=%b d=%0d, need v=1 d=20", ov8, od8);
                end
            end
            if (n == 4) begin
                tests++;
                if (ov8 !== 1'b0 || od8 !== '0 || ov12 !== 1'b0 || od12 !== '0) begin
                    fails++;
                    $display("FAIL rst_mid_clear: got v8=%b d8=%0d v12=%b d12=%0d, need all 0", ov8, od8, ov12, od12);
                end
            end
            if (n > 4) begin
                tests++;
                if (ov8 !== 1'b0 || ov12 !== 1'b0) begin
                    fails++;
                    $display("FAIL rst_mid_stale n=%0d: got v8=%b v12=%b, need 0", n, ov8, ov12);
                end
            end
            case (n)
                0: drive(1'b1, 1'b0, MODE_MED, wa, wa);
                1: drive(1'b1, 1'b0, MODE_MED, wb, wb);
                2: drive(1'b1, 1'b0, MODE_MED, wc, wc);
                3: begin rst_n = 1'b0; drive(1'b1, 1'b1, MODE_MED, wd, wd); end
                default: begin rst_n = 1'b1; drive(1'b0, 1'b0, MODE_MED, wd, wd); end
            endcase
        end
    endtask

    function automatic int rand_pix(input int width);
        int mx;
        mx = (1 << width) - 1;
        case ($urandom_range(0, 3))
            0:       return 0;
            1:       return mx;
            default: return int'($urandom) & mx;
        endcase
    endfunction

    task automatic test_random();
        int a[9];
        int b[9];
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            for (int k = 0; k < 9; k++) begin
                a[k] = rand_pix(W8);
                b[k] = rand_pix(W12);
            end
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                  2'($urandom_range(0, 3)), a, b);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, MODE_MED, a, b);
        repeat (8) @(negedge clk);
        tests++;
        if (q8.size() != 0 || q12.size() != 0) begin
            fails++;
            $display("FAIL random_drain: got %0d/%0d outstanding, need 0/0", q8.size(), q12.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        valid = 1'b0;
        mode  = MODE_MED;
        win8  = '0;
        win12 = '0;
        fork
            scoreboard();
        join_none
        test_reset();
        test_median();
        test_modes();
        test_stall();
        test_extremes();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
